gshare_btb_predictor: RTL and testbench
=======================================

Name: gshare_btb_predictor

Overview:
Parametrised next-generation branch predictor for the PROCESSOR fetch path. It replaces the bimodal-plus-untagged-BTB pair with a gshare pattern history table (PHT), a global history register (GHR) and a valid-bit BTB. It has a sequential table-clear sweep after reset.
Lookup is issued from IF and the result appears in ID one cycle later. Training is driven from EM using per-prediction metadata carried down the pipe.

Parameters:
PC_WIDTH, 32, PC and target width
SCALE, 10, index bits; PHT and BTB depth = 2**SCALE
HIST_LEN, 8, GHR bits; legal range 1..SCALE
CTR_WIDTH, 2, PHT saturating counter width; legal range 1..4
TAG_WIDTH, 8, BTB tag bits (used only with BP_BTB_TAG_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ready  out  1  high once the init sweep is done
bp_pc  in  PC_WIDTH  fetch PC (IF)
bp_oe  in  1  lookup enable; low = ID stalled, hold outputs
bp_taken  out  1  predicted taken (ID)
bp_hit  out  1  BTB entry valid (and tag match when tags enabled)
bp_target  out  PC_WIDTH  predicted target
bp_data  out  SCALE+CTR_WIDTH  metadata {pht_index, ctr}; pipeline carries it to EM
fb_pc  in  PC_WIDTH  PC of the resolving control transfer (EM)
fb_we  in  1  train strobe; asserted for JAL/JALR/BRANCH only
fb_taken  in  1  actual outcome
fb_target  in  PC_WIDTH  actual target, bit0 cleared by the core
fb_data  in  SCALE+CTR_WIDTH  metadata returned from EM

Behaviour:
- Reset (sync, active-high) sets outputs: ready=0, bp_taken=0, bp_hit=0, bp_target=0, bp_data=0. GHR=0. FSM enters INIT with sweep counter=0.
- FSM states:
  - INIT: each cycle writes entry [counter]: BTB valid=0, PHT ctr=2**(CTR_WIDTH-1)-1 (weakly not-taken). After counter reaches 2**SCALE-1 (2**SCALE cycles), go to RUN and set ready=1 on the next edge.
  - RUN: terminal until rst.
  - rst asserted mid-sweep or in RUN restarts INIT from 0.
- While INIT:
  - fb_we is ignored.
  - bp_taken and bp_hit are forced to 0.
  - bp_data is still produced.
- Index formation:
  - btb_idx = bp_pc[2+:SCALE].
  - pht_idx = bp_pc[2+:SCALE] XOR zero-extended GHR (GHR occupies the low HIST_LEN bits).
- Lookup latency is 1 cycle. Tables are synchronous read.
  - bp_oe=1 at edge N: outputs at N+1 reflect bp_pc sampled at N.
  - bp_oe=0: all bp_* outputs and the internal read registers hold.
- Prediction:
  - bp_taken = bp_hit & ctr[CTR_WIDTH-1].
  - bp_target = BTB target (0 when not a hit).
  - bp_data = {pht_idx, ctr}.
- Training when fb_we=1 in RUN, all on one edge:
  - PHT[fb_data.pht_index] <= saturating ctr±1, starting from fb_data.ctr; +1 if fb_taken, else −1. Saturates at 0 and at 2**CTR_WIDTH-1.
  - If fb_taken: BTB[fb_pc[2+:SCALE]] <= {valid=1, target=fb_target}. Not-taken does not allocate or invalidate.
  - GHR <= {GHR[HIST_LEN-2:0], fb_taken}. History is commit-time only; no speculative update and no recovery path.
- Same-cycle read and write to one entry: the read returns the old contents (read-first). The new value is visible to a lookup issued at the next edge.
- Two fb_we in consecutive cycles to the same PHT index: the second uses its own fb_data.ctr (last-writer-wins). This is accepted aliasing.

Optional Feature:
- Macro: BP_BTB_TAG_EN.
- Defined: each BTB entry also stores tag = pc[2+SCALE+:TAG_WIDTH], written on training.
  - bp_hit requires valid and a tag match against the sampled bp_pc.
  - Requires 2+SCALE+TAG_WIDTH <= PC_WIDTH; otherwise elaboration fails via a $error guard.
- Undefined: no tag storage; bp_hit = valid. TAG_WIDTH is ignored.

Decomposition:
- Package bp_pkg holds:
  - FSM state constants INIT/RUN;
  - the CTR_WIDTH-derived constants (weak-NT init value, max);
  - bp_data field offset/width functions;
  - the saturating-update function.
- Sub-module bp_table: parametrised 1-read/1-write synchronous RAM, read-first, with read-enable hold. It is instantiated for the PHT and for the BTB (valid+tag+target packed).

Test Plan:
- Init sweep (SCALE=4): rst 1 cycle, then release. ready rises exactly 16 cycles after reset release; fb_we pulsed during INIT leaves all entries cleared. A later lookup of any PC gives bp_hit=0, bp_taken=0, ctr=1.
- Train taken twice then predict: bp_pc=0x40 returns bp_data; train with fb_pc=0x40, fb_taken=1, fb_target=0x80. Repeat until ctr=3. Lookup of 0x40 with the matching GHR gives bp_hit=1, bp_taken=1, bp_target=0x80.
- Saturation: three taken trainings on ctr=3 keep ctr=3. Four not-taken trainings from 3 reach 0 and stay at 0; bp_taken=0 while bp_hit stays 1.
- History indexing: HIST_LEN=2, GHR forced to 2'b11 by two taken trainings. Lookup of PC 0x0 reports pht_index=3 in bp_data.
- Stall hold: bp_oe low for 3 cycles while bp_pc changes 0x40 to 0x44. bp_* outputs stay unchanged; bp_oe high updates them on the next cycle.
- Tags (BP_BTB_TAG_EN, SCALE=4): train 0x40 taken to 0x80, then look up 0x440 (same index, different tag). Response: bp_hit=0, bp_taken=0. Without the macro: bp_hit=1, bp_target=0x80.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare/BTB branch predictor: FSM states,
// counter constants, metadata field layout and the saturating counter update.
package bp_pkg;

  typedef enum logic {StInit, StRun} bp_state_e;

  // Weakly not-taken: the largest value whose MSB is still clear.
  function automatic int unsigned ctr_weak_nt(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned ctr_max(input int unsigned ctr_w);
    return (32'd1 << ctr_w) - 32'd1;
  endfunction

  // bp_data/fb_data layout is {pht_index, ctr}.
  function automatic int unsigned bp_data_ctr_lsb();
    return 32'd0;
  endfunction

  function automatic int unsigned bp_data_idx_lsb(input int unsigned ctr_w);
    return ctr_w;
  endfunction

  function automatic int unsigned bp_data_width(input int unsigned scale, input int unsigned ctr_w);
    return scale + ctr_w;
  endfunction

  // Counters are at most 4 bits wide; callers truncate to their own width.
  function automatic logic [3:0] ctr_sat_update(input logic [3:0] ctr, input logic inc,
                                                input int unsigned ctr_w);
    logic [3:0] max_v;
    max_v = 4'(ctr_max(ctr_w));
    if (inc) begin
      return (ctr == max_v) ? ctr : ctr + 4'd1;
    end
    return (ctr == 4'd0) ? ctr : ctr - 4'd1;
  endfunction

endpackage

// File: rtl/bp_table.sv
// 1R/1W synchronous-read RAM, read-first on address collision. The read
// register only loads while rd_en_i is high, so a stalled consumer sees stable data.
module bp_table #(
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [Width-1:0] rd_data_o,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i
);

  logic [Width-1:0] mem [2**AddrW];
  logic [Width-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (rd_en_i) begin
      rd_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/gshare_btb_predictor.sv
// Gshare PHT + global history + valid-bit BTB with a post-reset clear sweep.
// Define BP_BTB_TAG_EN to store and compare a partial PC tag in each BTB entry.
module gshare_btb_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned SCALE     = 10,
  parameter int unsigned HIST_LEN  = 8,
  parameter int unsigned CTR_WIDTH = 2,
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic [PC_WIDTH-1:0]        bp_pc,
  input  logic                       bp_oe,
  output logic                       bp_taken,
  output logic                       bp_hit,
  output logic [PC_WIDTH-1:0]        bp_target,
  output logic [SCALE+CTR_WIDTH-1:0] bp_data,
  input  logic [PC_WIDTH-1:0]        fb_pc,
  input  logic                       fb_we,
  input  logic                       fb_taken,
  input  logic [PC_WIDTH-1:0]        fb_target,
  input  logic [SCALE+CTR_WIDTH-1:0] fb_data
);

  localparam int unsigned DataW  = bp_data_width(SCALE, CTR_WIDTH);
  localparam int unsigned CtrLsb = bp_data_ctr_lsb();
  localparam int unsigned IdxLsb = bp_data_idx_lsb(CTR_WIDTH);
`ifdef BP_BTB_TAG_EN
  localparam int unsigned BtbW   = TAG_WIDTH + 1 + PC_WIDTH;

  if (2 + SCALE + TAG_WIDTH > PC_WIDTH) begin : g_tag_width_check
    $error("BTB tag field exceeds PC_WIDTH");
  end
`else
  localparam int unsigned BtbW   = 1 + PC_WIDTH;
  localparam int unsigned unused_tag_w = TAG_WIDTH;
`endif

  bp_state_e        state_q, state_d;
  logic [SCALE-1:0] sweep_q, sweep_d;
  logic [HIST_LEN-1:0] ghr_q;
  logic             init, train;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      StInit: begin
        sweep_d = sweep_q + SCALE'(1);
        if (sweep_q == {SCALE{1'b1}}) begin
          state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  assign init  = (state_q == StInit);
  assign train = fb_we & ~init;
  assign ready = (state_q == StRun);

  // History is updated only by committed outcomes; there is no speculative copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (train) begin
      ghr_q <= (ghr_q << 1) | HIST_LEN'(fb_taken);
    end
  end

  logic [SCALE-1:0]     pc_idx, pht_rd_idx, fb_pht_idx, fb_btb_idx;
  logic [CTR_WIDTH-1:0] fb_ctr, pht_wr_data, pht_rd_data;
  logic                 pht_wr_en, btb_wr_en;
  logic [SCALE-1:0]     pht_wr_addr, btb_wr_addr;
  logic [BtbW-1:0]      btb_wr_data, btb_rd_data;

  assign pc_idx     = bp_pc[2+:SCALE];
  assign pht_rd_idx = pc_idx ^ SCALE'(ghr_q);
  assign fb_pht_idx = fb_data[IdxLsb+:SCALE];
  assign fb_ctr     = fb_data[CtrLsb+:CTR_WIDTH];
  assign fb_btb_idx = fb_pc[2+:SCALE];

  always_comb begin
    pht_wr_en   = init | train;
    pht_wr_addr = fb_pht_idx;
    pht_wr_data = CTR_WIDTH'(ctr_sat_update(4'(fb_ctr), fb_taken, CTR_WIDTH));
    btb_wr_en   = init | (train & fb_taken);
    btb_wr_addr = fb_btb_idx;
`ifdef BP_BTB_TAG_EN
    btb_wr_data = {fb_pc[2+SCALE+:TAG_WIDTH], 1'b1, fb_target};
`else
    btb_wr_data = {1'b1, fb_target};
`endif
    if (init) begin
      pht_wr_addr = sweep_q;
      pht_wr_data = CTR_WIDTH'(ctr_weak_nt(CTR_WIDTH));
      btb_wr_addr = sweep_q;
      btb_wr_data = '0;
    end
  end

  bp_table #(
    .Width (CTR_WIDTH),
    .AddrW (SCALE)
  ) u_pht (
    .clk       (clk),
    .rst       (rst),
    .rd_en_i   (bp_oe),
    .rd_addr_i (pht_rd_idx),
    .rd_data_o (pht_rd_data),
    .wr_en_i   (pht_wr_en),
    .wr_addr_i (pht_wr_addr),
    .wr_data_i (pht_wr_data)
  );

  bp_table #(
    .Width (BtbW),
    .AddrW (SCALE)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_en_i   (bp_oe),
    .rd_addr_i (pc_idx),
    .rd_data_o (btb_rd_data),
    .wr_en_i   (btb_wr_en),
    .wr_addr_i (btb_wr_addr),
    .wr_data_i (btb_wr_data)
  );

  // Lookup-side registers share the table read enable so a stall holds everything.
  logic [SCALE-1:0] pht_idx_q;
  logic             run_q;
  logic             hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      pht_idx_q <= '0;
      run_q     <= 1'b0;
    end else if (bp_oe) begin
      pht_idx_q <= pht_rd_idx;
      run_q     <= ~init;
    end
  end

`ifdef BP_BTB_TAG_EN
  logic [TAG_WIDTH-1:0] tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
    end else if (bp_oe) begin
      tag_q <= bp_pc[2+SCALE+:TAG_WIDTH];
    end
  end

  assign hit = run_q & btb_rd_data[PC_WIDTH] & (btb_rd_data[BtbW-1-:TAG_WIDTH] == tag_q);
`else
  assign hit = run_q & btb_rd_data[PC_WIDTH];
`endif

  assign bp_hit    = hit;
  assign bp_taken  = hit & pht_rd_data[CTR_WIDTH-1];
  assign bp_target = hit ? btb_rd_data[PC_WIDTH-1:0] : '0;
  assign bp_data   = DataW'({pht_idx_q, pht_rd_data});

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp_pc, fb_pc};

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Scoreboard bench for gshare_btb_predictor (SCALE=4, HIST_LEN=2, CTR_WIDTH=2).
// Expected lookups are queued by the stimulus and checked by an independent monitor.
module tb_gshare_btb_predictor;

  localparam int unsigned PW = 32;
  localparam int unsigned SC = 4;
  localparam int unsigned HL = 2;
  localparam int unsigned CW = 2;
  localparam int unsigned DW = SC + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready;
  logic [PW-1:0] bp_pc = '0;
  logic          bp_oe = 1'b0;
  logic          bp_taken, bp_hit;
  logic [PW-1:0] bp_target;
  logic [DW-1:0] bp_data;
  logic [PW-1:0] fb_pc = '0;
  logic          fb_we = 1'b0;
  logic          fb_taken = 1'b0;
  logic [PW-1:0] fb_target = '0;
  logic [DW-1:0] fb_data = '0;

  gshare_btb_predictor #(
    .PC_WIDTH  (PW),
    .SCALE     (SC),
    .HIST_LEN  (HL),
    .CTR_WIDTH (CW),
    .TAG_WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .bp_pc     (bp_pc),
    .bp_oe     (bp_oe),
    .bp_taken  (bp_taken),
    .bp_hit    (bp_hit),
    .bp_target (bp_target),
    .bp_data   (bp_data),
    .fb_pc     (fb_pc),
    .fb_we     (fb_we),
    .fb_taken  (fb_taken),
    .fb_target (fb_target),
    .fb_data   (fb_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          hit;
    logic          taken;
    logic [PW-1:0] target;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic chk    = 1'b0;
  logic pend   = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) pend <= bp_oe & chk;

  always @(negedge clk) begin
    if (pend) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got a lookup, want none queued at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        cmp("bp_hit",    32'(bp_hit),    32'(e.hit));
        cmp("bp_taken",  32'(bp_taken),  32'(e.taken));
        cmp("bp_target", bp_target,      e.target);
        cmp("bp_data",   32'(bp_data),   32'(e.data));
      end
    end
  end

  task automatic look(input logic [PW-1:0] pc, input logic h, input logic t,
                      input logic [PW-1:0] tgt, input logic [DW-1:0] d);
    @(negedge clk);
    bp_pc = pc;
    bp_oe = 1'b1;
    chk   = 1'b1;
    fb_we = 1'b0;
    q.push_back('{hit: h, taken: t, target: tgt, data: d});
  endtask

  task automatic train(input logic [PW-1:0] pc, input logic tk, input logic [PW-1:0] tgt,
                       input logic [DW-1:0] d);
    @(negedge clk);
    bp_oe     = 1'b0;
    chk       = 1'b0;
    fb_we     = 1'b1;
    fb_pc     = pc;
    fb_taken  = tk;
    fb_target = tgt;
    fb_data   = d;
  endtask

  task automatic idle();
    @(negedge clk);
    bp_oe = 1'b0;
    chk   = 1'b0;
    fb_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, "_ready"},  32'(ready),    32'd0);
    cmp({tag, "_hit"},    32'(bp_hit),   32'd0);
    cmp({tag, "_taken"},  32'(bp_taken), 32'd0);
    cmp({tag, "_target"}, bp_target,     32'd0);
    cmp({tag, "_data"},   32'(bp_data),  32'd0);
  endtask

  // Counts edges from reset release until ready rises; 2**SC edges expected.
  task automatic wait_ready(input string tag);
    int cycles;
    cycles = 0;
    while (!ready && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    fb_we = 1'b0;
    cmp({tag, "_ready_latency"}, 32'(cycles), 32'd16);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Training strobes during the sweep must be ignored.
    rst       = 1'b0;
    fb_we     = 1'b1;
    fb_pc     = 32'h40;
    fb_taken  = 1'b1;
    fb_target = 32'h80;
    fb_data   = 6'h03;
    wait_ready("init");

    look(32'h40, 1'b0, 1'b0, 32'h0, 6'h01);
    look(32'h7C, 1'b0, 1'b0, 32'h0, 6'h3D);

    // Two taken trainings, then two not-taken to return the GHR to zero.
    train(32'h40, 1'b1, 32'h80, 6'h01);
    look(32'h40, 1'b1, 1'b0, 32'h80, 6'h05);
    train(32'h40, 1'b1, 32'h80, 6'h02);
    train(32'h40, 1'b0, 32'h0, 6'h15);
    train(32'h40, 1'b0, 32'h0, 6'h14);
    look(32'h40, 1'b1, 1'b1, 32'h80, 6'h03);

    // Upper saturation; GHR ends at 2'b11 so PC 0x0C maps to PHT[0].
    repeat (3) train(32'h40, 1'b1, 32'h80, 6'h03);
    look(32'h0C, 1'b0, 1'b0, 32'h0, 6'h03);

    // Down to zero and held there; GHR ends at 2'b00.
    train(32'h40, 1'b0, 32'h0, 6'h03);
    train(32'h40, 1'b0, 32'h0, 6'h02);
    train(32'h40, 1'b0, 32'h0, 6'h01);
    train(32'h40, 1'b0, 32'h0, 6'h00);
    look(32'h40, 1'b1, 1'b0, 32'h80, 6'h00);

    // History indexing: GHR -> 2'b11.
    train(32'h44, 1'b1, 32'h100, 6'h25);
    train(32'h44, 1'b1, 32'h100, 6'h26);
    look(32'h00, 1'b1, 1'b0, 32'h80, 6'h0D);
    look(32'h44, 1'b1, 1'b0, 32'h100, 6'h09);

    // Stall hold.
    look(32'h40, 1'b1, 1'b0, 32'h80, 6'h0D);
    @(negedge clk);
    bp_oe = 1'b0;
    chk   = 1'b0;
    bp_pc = 32'h44;
    repeat (2) begin
      @(negedge clk);
      cmp("hold_hit",    32'(bp_hit),  32'd1);
      cmp("hold_target", bp_target,    32'h80);
      cmp("hold_data",   32'(bp_data), 32'h0D);
    end
    look(32'h44, 1'b1, 1'b0, 32'h100, 6'h09);
    cmp("hold_last_target", bp_target, 32'h80);

    // Same index, different tag.
`ifdef BP_BTB_TAG_EN
    look(32'h440, 1'b0, 1'b0, 32'h0, 6'h0D);
`else
    look(32'h440, 1'b1, 1'b0, 32'h80, 6'h0D);
`endif

    // Read-first: lookup and training of the same entries on one edge.
    @(negedge clk);
    bp_pc     = 32'h48;
    bp_oe     = 1'b1;
    chk       = 1'b1;
    fb_we     = 1'b1;
    fb_pc     = 32'h48;
    fb_taken  = 1'b1;
    fb_target = 32'h200;
    fb_data   = 6'h05;
    q.push_back('{hit: 1'b0, taken: 1'b0, target: 32'h0, data: 6'h05});
    look(32'h48, 1'b1, 1'b1, 32'h200, 6'h06);
    idle();

    // Reset while running restarts the sweep and clears history.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rerun");
    rst = 1'b0;
    wait_ready("rerun");
    look(32'h48, 1'b0, 1'b0, 32'h0, 6'h09);
    idle();

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending lookups, want 0", q.size());
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
